sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one sram_controller port among NUM_CLIENTS requesters.
// Define SRAM_ARBITER_RR_EN for round-robin arbitration; default is fixed priority.
module sram_arbiter #(
    parameter int ADDR_BITS    = 20,
    parameter int DATA_BITS    = 16,
    parameter int NUM_CLIENTS  = 2,
    parameter int READ_LATENCY = 2,
    parameter int TURNAROUND   = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_CLIENTS-1:0]           req_valid,
    output logic [NUM_CLIENTS-1:0]           req_ready,
    input  logic [NUM_CLIENTS-1:0]           req_we,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0] req_addr,
    input  logic [NUM_CLIENTS*DATA_BITS-1:0] req_data,
    output logic [NUM_CLIENTS-1:0]           rsp_valid,
    output logic [DATA_BITS-1:0]             rsp_data,
    output logic                             ctrl_read_only,
    output logic [ADDR_BITS-1:0]             ctrl_addr,
    output logic [DATA_BITS-1:0]             ctrl_data_i,
    input  logic [DATA_BITS-1:0]             ctrl_data_o
);
    localparam int NC = NUM_CLIENTS;
    localparam int RL = READ_LATENCY;
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;

    logic                 r_dir;
    logic [1:0]           r_ta_cnt;
    logic                 r_pend_v;
    logic [IW-1:0]        r_pend_idx;
    logic                 r_rd_v;
    logic [IW-1:0]        r_rd_idx;
    logic [RL-1:0]        r_tag_v;
    logic [IW-1:0]        r_tag_idx [RL];
    logic                 r_ro;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_wdata;

    logic                 w_any;
    logic [IW-1:0]        w_lo;
    logic [IW-1:0]        w_win;
    logic                 w_we;
    logic [ADDR_BITS-1:0] w_addr;
    logic [DATA_BITS-1:0] w_data;
    logic                 w_block;
    logic [NC-1:0]        w_ready;
    logic                 w_accept;
    logic [NC-1:0]        w_rsp;

`ifdef SRAM_ARBITER_RR_EN
    logic [IW-1:0]        r_ptr;
    logic                 w_any_hi;
    logic [IW-1:0]        w_hi;

    // Pointer names the first client searched: one past the last grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (int'(w_win) == NC - 1) ? '0 : w_win + IW'(1);
        end
    end
`endif

    // Winner: the client held through a turnaround, else the first requester.
    always_comb begin
        w_any = 1'b0;
        w_lo  = '0;
`ifdef SRAM_ARBITER_RR_EN
        w_any_hi = 1'b0;
        w_hi     = '0;
`endif
        for (int i = NC - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_any = 1'b1;
                w_lo  = IW'(i);
`ifdef SRAM_ARBITER_RR_EN
                if (IW'(i) >= r_ptr) begin
                    w_any_hi = 1'b1;
                    w_hi     = IW'(i);
                end
`endif
            end
        end
        w_win = w_lo;
`ifdef SRAM_ARBITER_RR_EN
        if (w_any_hi) w_win = w_hi;
`endif
        if (r_pend_v) begin
            w_any = 1'b1;
            w_win = r_pend_idx;
        end
    end

    // Route the winning client's request fields.
    always_comb begin
        w_we   = 1'b0;
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NC; i++) begin
            if (w_win == IW'(i)) begin
                w_we   = req_we[i];
                w_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
                w_data = req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign w_block = (w_we != r_dir) && (r_ta_cnt != 2'd0);

    // Grant the winner unless it must wait out a direction change.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NC; i++) begin
            w_ready[i] = reset_n && w_any && !w_block &&
                         (w_win == IW'(i)) && req_valid[i];
        end
    end

    assign req_ready = w_ready;
    assign w_accept  = |w_ready;

    // Issue register, direction tracking and turnaround countdown.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ro       <= 1'b1;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_v     <= 1'b0;
            r_rd_idx   <= '0;
            r_dir      <= 1'b0;
            r_ta_cnt   <= 2'd0;
            r_pend_v   <= 1'b0;
            r_pend_idx <= '0;
        end else if (w_accept) begin
            r_ro     <= ~w_we;
            r_addr   <= w_addr;
            r_wdata  <= w_we ? w_data : '0;
            r_rd_v   <= ~w_we;
            r_rd_idx <= w_win;
            r_dir    <= w_we;
            r_ta_cnt <= 2'(TURNAROUND);
            r_pend_v <= 1'b0;
        end else begin
            r_ro    <= 1'b1;
            r_wdata <= '0;
            r_rd_v  <= 1'b0;
            if (r_ta_cnt != 2'd0) r_ta_cnt <= r_ta_cnt - 2'd1;
            if (w_any && w_block) begin
                r_pend_v   <= 1'b1;
                r_pend_idx <= w_win;
            end
        end
    end

    // Read tags ride a READ_LATENCY-deep pipe behind the issue cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_v <= '0;
            for (int k = 0; k < RL; k++) r_tag_idx[k] <= '0;
        end else begin
            r_tag_v[0]   <= r_rd_v;
            r_tag_idx[0] <= r_rd_idx;
            for (int k = 1; k < RL; k++) begin
                r_tag_v[k]   <= r_tag_v[k-1];
                r_tag_idx[k] <= r_tag_idx[k-1];
            end
        end
    end

    // Decode the tag leaving the pipe into a per-client strobe.
    always_comb begin
        w_rsp = '0;
        for (int i = 0; i < NC; i++) begin
            w_rsp[i] = r_tag_v[RL-1] && (r_tag_idx[RL-1] == IW'(i));
        end
    end

    assign rsp_valid      = w_rsp;
    assign rsp_data       = (|w_rsp) ? ctrl_data_o : '0;
    assign ctrl_read_only = r_ro;
    assign ctrl_addr      = r_addr;
    assign ctrl_data_i    = r_wdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random traffic checked against a
// transaction-level model of arbitration, turnaround and read return.
module tb_sram_arbiter;
    localparam int AB = 20;
    localparam int DB = 16;
    localparam int NC = 2;
    localparam int RL = 2;
    localparam int TA = 1;

    typedef struct packed {
        logic          we;
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
    } req_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NC-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [NC*AB-1:0] req_addr;
    logic [NC*DB-1:0] req_data;
    logic [DB-1:0]    rsp_data, ctrl_data_i, ctrl_data_o;
    logic             ctrl_read_only;
    logic [AB-1:0]    ctrl_addr;

    int checks = 0;
    int errors = 0;

    req_t q [NC][$];
    req_t cur [NC];
    bit   act [NC];

    int            cyc = 0;
    int            m_dir, m_last, m_pend, m_start;
    logic          m_ro;
    logic [AB-1:0] m_addr;
    logic [DB-1:0] m_wd;
    logic [NC-1:0] m_rv [16];

    always #5 clk = ~clk;

    sram_arbiter #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CLIENTS(NC),
        .READ_LATENCY(RL), .TURNAROUND(TA)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ctrl_read_only(ctrl_read_only), .ctrl_addr(ctrl_addr),
        .ctrl_data_i(ctrl_data_i), .ctrl_data_o(ctrl_data_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NC; i++) begin
            req_valid[i]          = act[i];
            req_we[i]             = cur[i].we;
            req_addr[i*AB +: AB]  = cur[i].addr;
            req_data[i*DB +: DB]  = cur[i].data;
        end
    endtask

    task automatic push(input int c, input logic we,
                        input logic [AB-1:0] a, input logic [DB-1:0] d);
        req_t r;
        r.we = we;
        r.addr = a;
        r.data = d;
        q[c].push_back(r);
    endtask

    task automatic m_reset();
        m_dir = 0;
        m_last = -1000;
        m_pend = -1;
        m_start = 0;
        m_ro = 1'b1;
        m_addr = '0;
        m_wd = '0;
        for (int k = 0; k < 16; k++) m_rv[k] = '0;
        for (int i = 0; i < NC; i++) begin
            act[i] = 1'b0;
            cur[i] = '0;
            q[i].delete();
        end
        drive();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_ctrl_ro", ctrl_read_only, 1);
        chk("rst_ctrl_addr", ctrl_addr, 0);
        chk("rst_ctrl_data_i", ctrl_data_i, 0);
    endtask

    task automatic cycle();
        int w;
        logic [NC-1:0] exp_rdy;
        logic [NC-1:0] rv;
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (!act[i] && q[i].size() > 0) begin
                cur[i] = q[i].pop_front();
                act[i] = 1'b1;
            end
        end
        drive();
        ctrl_data_o = DB'($urandom);
        @(negedge clk);
        chk("ctrl_read_only", ctrl_read_only, m_ro);
        chk("ctrl_addr", ctrl_addr, m_addr);
        chk("ctrl_data_i", ctrl_data_i, m_wd);
        rv = m_rv[cyc % 16];
        chk("rsp_valid", rsp_valid, rv);
        chk("rsp_data", rsp_data, (rv != 0) ? ctrl_data_o : '0);
        m_rv[cyc % 16] = '0;
        w = -1;
        if (m_pend >= 0) begin
            w = m_pend;
        end else begin
            for (int k = 0; k < NC; k++) begin
                int i;
                i = (m_start + k) % NC;
                if (w < 0 && act[i]) w = i;
            end
        end
        exp_rdy = '0;
        m_ro = 1'b1;
        m_wd = '0;
        if (w >= 0) begin
            if ((int'(cur[w].we) != m_dir) && (cyc - m_last <= TA)) begin
                m_pend = w;
            end else begin
                exp_rdy[w] = 1'b1;
                m_pend = -1;
                m_dir = int'(cur[w].we);
                m_last = cyc;
`ifdef SRAM_ARBITER_RR_EN
                m_start = (w + 1) % NC;
`else
                m_start = 0;
`endif
                m_ro = ~cur[w].we;
                m_addr = cur[w].addr;
                m_wd = cur[w].we ? cur[w].data : '0;
                if (!cur[w].we) m_rv[(cyc + 1 + RL) % 16][w] = 1'b1;
                act[w] = 1'b0;
            end
        end
        chk("req_ready", req_ready, exp_rdy);
        cyc++;
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            if (q[0].size() == 0 && q[1].size() == 0 && !act[0] && !act[1])
                break;
            cycle();
        end
        repeat (RL + 3) cycle();
    endtask

    initial begin
        m_reset();
        ctrl_data_o = 16'h1234;
        #12;
        chk_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // client0 single read
        push(0, 1'b0, 20'h00010, 16'h0);
        repeat (6) cycle();

        // client1 write then read: turnaround gap
        push(1, 1'b1, 20'h00020, 16'hBEEF);
        push(1, 1'b0, 20'h00021, 16'h0);
        repeat (8) cycle();

        // both clients hold reads continuously
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NC; i++)
                if (q[i].size() == 0) push(i, 1'b0, AB'($urandom), 16'h0);
            cycle();
        end
        drain();

        // eight back-to-back reads from client0
        for (int k = 0; k < 8; k++) push(0, 1'b0, AB'(32'h100 + k), 16'h0);
        repeat (14) cycle();

        // write to 0x5 then a long idle stretch
        push(0, 1'b1, 20'h00005, 16'hA5A5);
        repeat (12) cycle();

        // reset with two reads in flight
        push(0, 1'b0, 20'h00300, 16'h0);
        push(0, 1'b0, 20'h00301, 16'h0);
        repeat (3) cycle();
        #2;
        reset_n = 1'b0;
        cur[1].we = 1'b0;
        cur[1].addr = 20'h00777;
        act[1] = 1'b1;
        drive();
        ctrl_data_o = 16'hFFFF;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        repeat (8) cycle();

        // random mixed traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NC; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 3) == 0)
                    push(i, 1'($urandom), AB'($urandom_range(0, 63)),
                         DB'($urandom));
            end
            cycle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
